// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: instruction type codes, RV32 opcode constants and the opcode-to-type decode.
package inst_encoder_pkg;
  localparam logic [2:0] NULL_TYPE = 3'd0;
  localparam logic [2:0] R_TYPE    = 3'd1;
  localparam logic [2:0] I_TYPE    = 3'd2;
  localparam logic [2:0] S_TYPE    = 3'd3;
  localparam logic [2:0] U_TYPE    = 3'd4;
  localparam logic [2:0] J_TYPE    = 3'd5;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  function automatic logic [2:0] op_type(input logic [6:0] op);
    case (op)
      OP_R:                     return R_TYPE;
      OP_IMM, OP_JALR, OP_LOAD: return I_TYPE;
      OP_STORE:                 return S_TYPE;
      OP_LUI, OP_AUIPC:         return U_TYPE;
      OP_JAL:                   return J_TYPE;
      default:                  return NULL_TYPE;
    endcase
  endfunction
endpackage

// File: rtl/inst_packer.sv
// inst_packer: packs decoded fields into a 32-bit RV32 instruction word by type.
module inst_packer
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  i_itype,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word
);
  always_comb begin
    o_word = (i_itype == R_TYPE) ? {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode} :
             (i_itype == I_TYPE) ? {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode} :
             (i_itype == S_TYPE) ? {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode} :
             (i_itype == U_TYPE) ? {i_imm[31:12], i_rd, i_opcode} :
             (i_itype == J_TYPE) ? {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode} :
                                   32'h0;
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: checks and packs decoded instructions, then streams them into imem
// through a single register stage with an auto-incrementing write address.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_itype,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        clr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        full,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic [15:0] wr_cnt
);
  logic        r_wvalid, r_full, r_err;
  logic [31:0] r_waddr, r_wdata;
  logic [7:0]  r_err_cnt;
  logic [15:0] r_wr_cnt;
  logic [31:0] w_word;
  logic        w_legal, w_acc, w_hs;
  inst_packer u_packer (
    .i_itype(in_itype), .i_opcode(in_opcode), .i_rd(in_rd), .i_rs1(in_rs1), .i_rs2(in_rs2),
    .i_funct3(in_funct3), .i_funct7(in_funct7), .i_imm(in_imm), .o_word(w_word)
  );
  assign in_ready = !r_full && !clr && (!r_wvalid || wready);
  assign w_legal  = (in_itype != NULL_TYPE) && (op_type(in_opcode) == in_itype);
  assign w_acc    = in_valid && in_ready;
  assign w_hs     = r_wvalid && wready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wvalid  <= 1'b0;
      r_wdata   <= 32'h0;
      r_waddr   <= BASE_ADDR;
      r_full    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'h0;
      r_wr_cnt  <= 16'h0;
    end else if (clr) begin
      r_wvalid  <= 1'b0;
      r_waddr   <= BASE_ADDR;
      r_full    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'h0;
      r_wr_cnt  <= 16'h0;
    end else begin
      r_err <= w_acc && !w_legal;
      if (w_acc && !w_legal) r_err_cnt <= r_err_cnt + 8'(r_err_cnt != 8'hFF);
      if (w_hs) begin
        r_waddr  <= r_waddr + 32'd4;
        r_wr_cnt <= r_wr_cnt + 16'd1;
        if (r_wr_cnt == 16'(DEPTH - 1)) r_full <= 1'b1;
      end
      // A fresh legal word keeps wvalid high so back-to-back writes run one per cycle.
      if (w_acc && w_legal) begin
        r_wvalid <= 1'b1;
        r_wdata  <= w_word;
      end else if (w_hs) r_wvalid <= 1'b0;
    end
  end
  assign wvalid  = r_wvalid;
  assign wdata   = r_wdata;
  assign waddr   = r_waddr;
  assign full    = r_full;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign wr_cnt  = r_wr_cnt;
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed scenarios plus randomized traffic against a behavioural model (DEPTH=4 build).
module tb_inst_encoder;
  import inst_encoder_pkg::*;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEP = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, clr = 0, wvalid, wready = 1, full, err;
  logic [2:0] in_itype = 0, in_funct3 = 0;
  logic [6:0] in_opcode = 0, in_funct7 = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0] in_imm = 0, waddr, wdata;
  logic [7:0] err_cnt;
  logic [15:0] wr_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_itype(in_itype),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .clr(clr), .wvalid(wvalid), .wready(wready),
    .waddr(waddr), .wdata(wdata), .full(full), .err(err), .err_cnt(err_cnt), .wr_cnt(wr_cnt)
  );
  function automatic logic [2:0] ref_type(input logic [6:0] op);
    logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F};
    logic [2:0] tys [8] = '{R_TYPE, I_TYPE, I_TYPE, I_TYPE, S_TYPE, U_TYPE, U_TYPE, J_TYPE};
    for (int k = 0; k < 8; k++) if (ops[k] == op) return tys[k];
    return NULL_TYPE;
  endfunction
  function automatic logic [31:0] ref_word(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] base = 32'(op) + 32'(f3) * 4096 + 32'(rs1) * 32768;
    if (t == R_TYPE) return base + 32'(rd) * 128 + 32'(rs2) * (1 << 20) + 32'(f7) * (1 << 25);
    if (t == I_TYPE) return base + 32'(rd) * 128 + (imm % 4096) * (1 << 20);
    if (t == S_TYPE) return base + (imm % 32) * 128 + 32'(rs2) * (1 << 20) + ((imm / 32) % 128) * (1 << 25);
    if (t == U_TYPE) return 32'(op) + 32'(rd) * 128 + (imm / 4096) * 4096;
    return 32'(op) + 32'(rd) * 128 + ((imm / 4096) % 256) * 4096 + ((imm / 2048) % 2) * (1 << 20)
         + ((imm / 2) % 1024) * (1 << 21) + ((imm / (1 << 20)) % 2) * (1 << 31);
  endfunction
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_valid = 1; in_itype = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask
  task automatic pulse_clr(); in_valid = 0; clr = 1; tick(); clr = 0; endtask
  task automatic test_reset();
    rst_n = 0; tick(); tick();
    checks++; if (wvalid !== 0) begin errors++; $display("FAIL reset_wvalid got %b exp 0", wvalid); end
    checks++; if (wdata !== 0) begin errors++; $display("FAIL reset_wdata got %h exp 0", wdata); end
    checks++; if (waddr !== BASE) begin errors++; $display("FAIL reset_waddr got %h exp %h", waddr, BASE); end
    checks++; if ({full, err, err_cnt, wr_cnt} !== 0) begin errors++; $display("FAIL reset_flags got %b%b %h %h exp 0", full, err, err_cnt, wr_cnt); end
    rst_n = 1;
  endtask
  task automatic test_addi();
    wready = 1; req(I_TYPE, OP_IMM, 1, 0, 0, 0, 0, 5); #1;
    checks++; if (in_ready !== 1) begin errors++; $display("FAIL addi_ready got %b exp 1", in_ready); end
    tick(); in_valid = 0;
    checks++; if ({wvalid, wdata, waddr} !== {1'b1, 32'h00500093, BASE}) begin errors++; $display("FAIL addi_word got %b %h %h exp 1 00500093 %h", wvalid, wdata, waddr, BASE); end
    tick();
    checks++; if ({wvalid, wr_cnt, waddr} !== {1'b0, 16'd1, BASE + 32'd4}) begin errors++; $display("FAIL addi_after got %b %0d %h exp 0 1 %h", wvalid, wr_cnt, waddr, BASE + 4); end
    pulse_clr();
    checks++; if ({waddr, wr_cnt} !== {BASE, 16'd0}) begin errors++; $display("FAIL clr_addr got %h %0d exp %h 0", waddr, wr_cnt, BASE); end
  endtask
  task automatic test_back_to_back();
    req(R_TYPE, OP_R, 3, 1, 2, 0, 0, 0); tick();
    req(S_TYPE, OP_STORE, 0, 1, 2, 2, 0, 8); #1;
    checks++; if ({wvalid, wdata, waddr, in_ready} !== {1'b1, 32'h002081B3, BASE, 1'b1}) begin errors++; $display("FAIL b2b_add got %b %h %h %b exp 1 002081b3 %h 1", wvalid, wdata, waddr, in_ready, BASE); end
    tick(); in_valid = 0;
    checks++; if ({wvalid, wdata, waddr} !== {1'b1, 32'h0020A423, BASE + 32'd4}) begin errors++; $display("FAIL b2b_sw got %b %h %h exp 1 0020a423 %h", wvalid, wdata, waddr, BASE + 4); end
    tick();
    checks++; if ({wvalid, wr_cnt} !== {1'b0, 16'd2}) begin errors++; $display("FAIL b2b_cnt got %b %0d exp 0 2", wvalid, wr_cnt); end
    pulse_clr();
  endtask
  task automatic test_j_u();
    req(J_TYPE, OP_JAL, 1, 0, 0, 0, 0, 32'h800); tick();
    req(U_TYPE, OP_LUI, 5, 0, 0, 0, 0, 32'h12345000);
    checks++; if (wdata !== 32'h001000EF) begin errors++; $display("FAIL jal_word got %h exp 001000ef", wdata); end
    tick(); in_valid = 0;
    checks++; if (wdata !== 32'h123452B7) begin errors++; $display("FAIL lui_word got %h exp 123452b7", wdata); end
    tick(); pulse_clr();
  endtask
  task automatic test_illegal();
    req(I_TYPE, OP_R, 1, 2, 3, 0, 0, 0); tick(); in_valid = 0;
    checks++; if ({wvalid, err, err_cnt} !== {1'b0, 1'b1, 8'd1}) begin errors++; $display("FAIL illegal_err got %b %b %0d exp 0 1 1", wvalid, err, err_cnt); end
    req(I_TYPE, OP_IMM, 1, 0, 0, 0, 0, 5); tick(); in_valid = 0;
    checks++; if ({err, wvalid, waddr} !== {1'b0, 1'b1, BASE}) begin errors++; $display("FAIL illegal_next got %b %b %h exp 0 1 %h", err, wvalid, waddr, BASE); end
    tick(); pulse_clr();
  endtask
  task automatic test_stall();
    wready = 0; req(I_TYPE, OP_IMM, 1, 0, 0, 0, 0, 5); tick();
    req(R_TYPE, OP_R, 3, 1, 2, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if ({wvalid, wdata, waddr, in_ready} !== {1'b1, 32'h00500093, BASE, 1'b0}) begin errors++; $display("FAIL stall_hold%0d got %b %h %h %b", k, wvalid, wdata, waddr, in_ready); end
    end
    wready = 1; tick(); in_valid = 0;
    checks++; if ({wvalid, wdata, waddr} !== {1'b1, 32'h002081B3, BASE + 32'd4}) begin errors++; $display("FAIL stall_second got %b %h %h exp 1 002081b3 %h", wvalid, wdata, waddr, BASE + 4); end
    tick();
    checks++; if ({wvalid, wr_cnt} !== {1'b0, 16'd2}) begin errors++; $display("FAIL stall_cnt got %b %0d exp 0 2", wvalid, wr_cnt); end
    pulse_clr();
  endtask
  task automatic test_full();
    for (int k = 0; k < DEP; k++) begin req(I_TYPE, OP_IMM, 5'(k), 0, 0, 0, 0, 32'(k)); tick(); end
    in_valid = 0; tick();
    req(I_TYPE, OP_IMM, 1, 0, 0, 0, 0, 1); #1;
    checks++; if ({full, in_ready, waddr, wr_cnt} !== {1'b1, 1'b0, BASE + 32'h10, 16'd4}) begin errors++; $display("FAIL full_state got %b %b %h %0d exp 1 0 %h 4", full, in_ready, waddr, wr_cnt, BASE + 16); end
    tick();
    checks++; if ({full, wvalid, waddr} !== {1'b1, 1'b0, BASE + 32'h10}) begin errors++; $display("FAIL full_hold got %b %b %h", full, wvalid, waddr); end
    clr = 1; #1;
    checks++; if (in_ready !== 0) begin errors++; $display("FAIL clr_ready got %b exp 0", in_ready); end
    tick(); clr = 0; in_valid = 0;
    checks++; if ({full, waddr, wr_cnt, wvalid} !== {1'b0, BASE, 16'd0, 1'b0}) begin errors++; $display("FAIL full_clr got %b %h %0d %b", full, waddr, wr_cnt, wvalid); end
    wready = 0; req(U_TYPE, OP_AUIPC, 2, 0, 0, 0, 0, 32'hABCDE000); tick(); tick(); in_valid = 0;
    rst_n = 0; tick();
    checks++; if ({wvalid, waddr} !== {1'b0, BASE}) begin errors++; $display("FAIL rst_stall got %b %h exp 0 %h", wvalid, waddr, BASE); end
    rst_n = 1; wready = 1;
  endtask
  task automatic test_random();
    logic m_wv = 0, m_full = 0, m_err = 0, m_rdy, acc, lg, hs;
    logic [31:0] m_wd = 0, m_wa = BASE;
    logic [7:0] m_ec = 0;
    logic [15:0] m_wc = 0;
    logic [6:0] ops [8] = '{OP_R, OP_IMM, OP_JALR, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JAL};
    pulse_clr();
    m_wd = wdata;
    for (int c = 0; c < 400; c++) begin
      logic [6:0] op = ops[$urandom_range(0, 7)];
      logic [2:0] t = ref_type(op);
      if ($urandom_range(0, 4) == 0) t = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      req(t, op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), $urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      wready = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 11) == 0);
      #1;
      m_rdy = !m_full && !clr && (!m_wv || wready);
      checks++; if (in_ready !== m_rdy) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, in_ready, m_rdy); end
      acc = in_valid && m_rdy;
      lg = (t != NULL_TYPE) && (ref_type(op) == t);
      hs = m_wv && wready;
      if (clr) begin
        m_wv = 0; m_wa = BASE; m_full = 0; m_err = 0; m_ec = 0; m_wc = 0;
      end else begin
        m_err = acc && !lg;
        if (m_err && m_ec != 255) m_ec++;
        if (hs) begin m_wa += 4; m_wc++; if (m_wc == DEP) m_full = 1; end
        if (acc && lg) begin m_wv = 1; m_wd = ref_word(t, op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm); end
        else if (hs) m_wv = 0;
      end
      tick(); clr = 0;
      checks++; if ({wvalid, waddr, full, err, err_cnt, wr_cnt} !== {m_wv, m_wa, m_full, m_err, m_ec, m_wc}) begin errors++; $display("FAIL rnd_state c%0d got %b %h %b %b %0d %0d exp %b %h %b %b %0d %0d", c, wvalid, waddr, full, err, err_cnt, wr_cnt, m_wv, m_wa, m_full, m_err, m_ec, m_wc); end
      if (m_wv) begin checks++; if (wdata !== m_wd) begin errors++; $display("FAIL rnd_wdata c%0d got %h exp %h", c, wdata, m_wd); end end
    end
    in_valid = 0; wready = 1;
  endtask
  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_j_u();
    test_illegal();
    test_stall();
    test_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Builds 32-bit RV32 instruction words from decoded fields (type, opcode, registers, funct, immediate), the inverse of the opcode-to-type decode in the ID stage.
- Checks opcode/type consistency against the decode table and streams the accepted words into instruction memory over a write handshake, with an auto-incrementing address.
- Used by the self-test / program-loader path of npc to place generated programs into imem before the core is released.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of the first written word.
- DEPTH, 1024, maximum number of words written before the block reports full.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_itype  input  3  instruction type, using the shared `R_TYPE/`I_TYPE/`S_TYPE/`U_TYPE/`J_TYPE/`NULL_TYPE codes.
- in_opcode  input  7  opcode field.
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field (R only).
- in_imm  input  32  immediate as a full byte value; U uses imm[31:12], others use the low bits.
- clr  input  1  restart at BASE_ADDR and zero the counters.
- wvalid  output  1  memory write valid.
- wready  input  1  memory accepts the write.
- waddr  output  32  write byte address.
- wdata  output  32  encoded instruction.
- full  output  1  DEPTH words have been written.
- err  output  1  one-cycle pulse when a request is rejected.
- err_cnt  output  8  saturating count of rejected requests.
- wr_cnt  output  16  count of words written.

Behaviour:
- Reset (rst_n=0 at an edge), which dominates clr and any in-flight transfer:
  - wvalid=0, wdata=0, waddr=BASE_ADDR, full=0, err=0, err_cnt=0, wr_cnt=0.
  - Any pending word is discarded.
- Pipeline: one register stage (S1) between input and write port.
  - in_ready = !full && !clr && (!wvalid || wready).
  - Input accepted when in_valid && in_ready.
  - Latency: an accepted valid request drives wvalid=1 on the next cycle.
- Consistency check, combinational on the inputs, at acceptance. A request is legal iff:
  - opcode 0110011 → R.
  - opcode 0010011, 1100111 or 0000011 → I.
  - opcode 0100011 → S.
  - opcode 0110111 or 0010111 → U.
  - opcode 1101111 → J.
  - in_itype equals the type above.
- Any other opcode, NULL type, or a type mismatch is illegal:
  - Request is consumed (in_ready handshake completes).
  - No write is produced.
  - err=1 for exactly the next cycle.
  - err_cnt increments, saturating at 255.
- Packing, bit ranges of wdata:
  - R: funct7[31:25] rs2[24:20] rs1[19:15] funct3[14:12] rd[11:7] opcode[6:0].
  - I: imm[11:0]→[31:20], rs1, funct3, rd, opcode.
  - S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7], opcode.
  - U: imm[31:12]→[31:12], rd, opcode.
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12], rd, opcode.
  - Unused fields and imm bits are ignored.
  - J imm[0] is ignored without an error.
- Write port:
  - wdata and waddr are held stable while wvalid && !wready.
  - On wvalid && wready: waddr += 4, wr_cnt += 1.
  - If the next accepted request is a legal word, wvalid stays 1 (back-to-back, one word per cycle at full throughput).
- Full:
  - full is set in the cycle after the DEPTH-th write handshake. waddr then equals BASE_ADDR + 4*DEPTH and is not advanced further.
  - While full, in_ready=0.
  - Only clr or reset clears full.
- clr is a one-cycle synchronous pulse:
  - waddr=BASE_ADDR, wr_cnt=0, err_cnt=0, full=0, wvalid=0.
  - Any pending un-handshaked word is dropped.
  - in_ready=0 in the clr cycle.
- Simultaneous events:
  - clr in the same cycle as a write handshake: clr wins; the address and count do not advance.
  - An illegal request arriving while a word is pending: it waits behind in_ready like any other request.

Decomposition:
- Shared define header holds the existing type codes plus the new opcode constants (OP_R, OP_IMM, OP_JALR, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JAL).
- One combinational sub-module, inst_packer: (itype, fields, imm) → 32-bit word.
- The consistency check reuses the existing type-decode module on in_opcode and compares its output with in_itype.
- Handshake, counters and the full flag live in inst_encoder.

Test Plan:
- After reset, send addi x1,x0,5 (I, op 0010011, rd1, imm 5) with wready=1 → next cycle wvalid=1, wdata=0x00500093, waddr=0x80000000; then wr_cnt=1.
- Back-to-back add x3,x1,x2 then sw x2,8(x1) → wdata 0x002081B3 @0x80000000, then 0x0020A423 @0x80000004, one per cycle.
- jal x1 with imm 0x800, and lui x5 with imm 0x12345000 → 0x001000EF, then 0x123452B7.
- op 0110011 with itype I → no wvalid, err pulse for 1 cycle, err_cnt=1; a following legal request still writes at an unchanged waddr.
- Hold wready=0 for 5 cycles with a second request waiting → wdata/waddr stable, in_ready=0; after release both words are written in order.
- DEPTH=4 build: write 4 words → full=1, in_ready=0, waddr=0x80000010; pulse clr → full=0, waddr=0x80000000, wr_cnt=0. Also assert rst_n=0 mid-stall → wvalid=0 on the next edge.
